// File: rtl/sseg_page_sched.sv
// Page scheduler for the 4-digit seven-segment driver: rotates through enabled page
// configs with a fixed dwell and lets a one-shot alert pre-empt the rotation.
module sseg_page_sched #(
  parameter int unsigned DWELL       = 100_000_000,
  parameter int unsigned ALERT_DWELL = 200_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_page,
  input  logic [13:0] wr_cnt1,
  input  logic [6:0]  wr_cnt2,
  input  logic [1:0]  wr_mode,
  input  logic        wr_sign,
  input  logic        wr_dp_en,
  input  logic [1:0]  wr_dp_sel,
  input  logic [3:0]  page_mask,
  input  logic        alert_req,
  input  logic [13:0] alert_cnt1,
  output logic        alert_ack,
  output logic        alert_busy,
  output logic [1:0]  cur_page,
  output logic [13:0] cnt1,
  output logic [6:0]  cnt2,
  output logic        valid,
  output logic        dp_en,
  output logic [1:0]  dp_sel,
  output logic [1:0]  mod_sel,
  output logic        sign,
  output logic [1:0]  fsm_state
);

  localparam int unsigned MAXD = (DWELL > ALERT_DWELL) ? DWELL : ALERT_DWELL;
  localparam int CW = $clog2(MAXD);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] ALERT_LAST = CW'(ALERT_DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_ALERT = 2'd2
  } state_t;

  typedef struct packed {
    logic [13:0] cnt1;
    logic [6:0]  cnt2;
    logic [1:0]  mode;
    logic        sign;
    logic        dp_en;
    logic [1:0]  dp_sel;
  } page_t;

  state_t         state;
  page_t          pages [4];
  page_t          wr_cfg;
  logic [CW-1:0]  dwell_cnt;
  logic [13:0]    alert_val;

  assign fsm_state = state;

  // Next enabled page after cur, wrapping; returns cur when it is the only one set.
  function automatic logic [1:0] next_page(input logic [1:0] cur, input logic [3:0] mask);
    logic [1:0] idx;
    next_page = cur;
    for (int i = 3; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (mask[idx]) next_page = idx;
    end
  endfunction

  function automatic logic [1:0] first_page(input logic [3:0] mask);
    first_page = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) first_page = 2'(i);
    end
  endfunction

  always_comb begin
    wr_cfg.cnt1   = wr_cnt1;
    wr_cfg.cnt2   = wr_cnt2;
    wr_cfg.mode   = wr_mode;
    wr_cfg.sign   = wr_sign;
    wr_cfg.dp_en  = wr_dp_en;
    wr_cfg.dp_sel = wr_dp_sel;
    case (wr_mode)
      2'b00: wr_cfg.cnt1 = {6'd0, wr_cnt1[7:0]};
      2'b01: begin
        if (wr_cnt1 > 14'd99) wr_cfg.cnt1 = 14'd99;
        if (wr_cnt2 > 7'd99)  wr_cfg.cnt2 = 7'd99;
      end
      2'b10: if (wr_cnt1 > 14'd9999) wr_cfg.cnt1 = 14'd9999;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) pages[i] <= '0;
    end else if (wr_en) begin
      pages[wr_page] <= wr_cfg;
    end
  end

  // Handshake: alert_req is a level held by the requester until alert_ack, which is a
  // single-cycle grant issued on the edge the FSM enters ALERT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cur_page   <= 2'd0;
      dwell_cnt  <= '0;
      alert_val  <= 14'd0;
      alert_ack  <= 1'b0;
      alert_busy <= 1'b0;
      cnt1       <= 14'd0;
      cnt2       <= 7'd0;
      valid      <= 1'b0;
      dp_en      <= 1'b0;
      dp_sel     <= 2'd0;
      mod_sel    <= 2'd0;
      sign       <= 1'b0;
    end else begin
      alert_ack <= 1'b0;

      // Display registers follow the state one cycle behind.
      case (state)
        S_SHOW: begin
          cnt1    <= pages[cur_page].cnt1;
          cnt2    <= pages[cur_page].cnt2;
          mod_sel <= pages[cur_page].mode;
          sign    <= pages[cur_page].sign;
          dp_en   <= pages[cur_page].dp_en;
          dp_sel  <= pages[cur_page].dp_sel;
          valid   <= 1'b1;
        end
        S_ALERT: begin
          cnt1    <= alert_val;
          cnt2    <= 7'd0;
          mod_sel <= 2'b10;
          sign    <= 1'b0;
          dp_en   <= 1'b0;
          dp_sel  <= 2'd0;
          valid   <= 1'b1;
        end
        default: valid <= 1'b0;
      endcase

      case (state)
        S_IDLE, S_SHOW: begin
          if (alert_req && !alert_busy) begin
            state      <= S_ALERT;
            alert_ack  <= 1'b1;
            alert_busy <= 1'b1;
            alert_val  <= (alert_cnt1 > 14'd9999) ? 14'd9999 : alert_cnt1;
            dwell_cnt  <= '0;
          end else if (page_mask == 4'd0) begin
            state <= S_IDLE;
          end else if (state == S_IDLE) begin
            state     <= S_SHOW;
            cur_page  <= first_page(page_mask);
            dwell_cnt <= '0;
          end else if (dwell_cnt == DWELL_LAST || !page_mask[cur_page]) begin
            cur_page  <= next_page(cur_page, page_mask);
            dwell_cnt <= '0;
          end else begin
            dwell_cnt <= dwell_cnt + CW'(1);
          end
        end
        S_ALERT: begin
          if (dwell_cnt == ALERT_LAST) begin
            state      <= (page_mask != 4'd0) ? S_SHOW : S_IDLE;
            alert_busy <= 1'b0;
            dwell_cnt  <= '0;
          end else begin
            dwell_cnt <= dwell_cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_page_sched.sv
// Self-checking bench for sseg_page_sched with short dwells; expected display words
// are queued per phase and compared cycle by cycle.
module tb_sseg_page_sched;

  localparam int DWELL       = 4;
  localparam int ALERT_DWELL = 6;
  localparam int W           = 30;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wr_en = 1'b0;
  logic [1:0]  wr_page = '0;
  logic [13:0] wr_cnt1 = '0;
  logic [6:0]  wr_cnt2 = '0;
  logic [1:0]  wr_mode = '0;
  logic        wr_sign = 1'b0;
  logic        wr_dp_en = 1'b0;
  logic [1:0]  wr_dp_sel = '0;
  logic [3:0]  page_mask = '0;
  logic        alert_req = 1'b0;
  logic [13:0] alert_cnt1 = '0;
  logic        alert_ack, alert_busy, valid, dp_en, sign;
  logic [1:0]  cur_page, dp_sel, mod_sel, fsm_state;
  logic [13:0] cnt1;
  logic [6:0]  cnt2;

  sseg_page_sched #(.DWELL(DWELL), .ALERT_DWELL(ALERT_DWELL)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_page(wr_page), .wr_cnt1(wr_cnt1), .wr_cnt2(wr_cnt2),
    .wr_mode(wr_mode), .wr_sign(wr_sign), .wr_dp_en(wr_dp_en), .wr_dp_sel(wr_dp_sel),
    .page_mask(page_mask), .alert_req(alert_req), .alert_cnt1(alert_cnt1),
    .alert_ack(alert_ack), .alert_busy(alert_busy), .cur_page(cur_page),
    .cnt1(cnt1), .cnt2(cnt2), .valid(valid), .dp_en(dp_en), .dp_sel(dp_sel),
    .mod_sel(mod_sel), .sign(sign), .fsm_state(fsm_state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_w;
  int n_cmp = 0;
  int n_err = 0;

  assign obs_w = {valid, mod_sel, cnt1, cnt2, sign, dp_en, dp_sel, alert_ack, alert_busy};

  function automatic logic [W-1:0] disp(input logic v, input logic [1:0] m,
                                        input logic [13:0] c1, input logic [6:0] c2,
                                        input logic s, input logic de, input logic [1:0] ds,
                                        input logic ack, input logic busy);
    return {v, m, c1, c2, s, de, ds, ack, busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [W-1:0] w);
    for (int i = 0; i < n; i++) exp_q.push_back(w);
  endtask

  task automatic drain(input string tag);
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check(tag, {2'b00, obs_w}, {2'b00, e});
    end
  endtask

  task automatic set_wr(input logic [1:0] pg, input logic [13:0] c1, input logic [6:0] c2,
                        input logic [1:0] m, input logic s, input logic de, input logic [1:0] ds);
    wr_en = 1'b1; wr_page = pg; wr_cnt1 = c1; wr_cnt2 = c2;
    wr_mode = m; wr_sign = s; wr_dp_en = de; wr_dp_sel = ds;
  endtask

  task automatic write_page(input logic [1:0] pg, input logic [13:0] c1, input logic [6:0] c2,
                            input logic [1:0] m, input logic s, input logic de, input logic [1:0] ds);
    set_wr(pg, c1, c2, m, s, de, ds);
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] zero_w, p0_w, p2_w, p1a_w, p1b_w, p0z_w;
    logic [13:0] av;
    zero_w = '0;
    p0_w   = disp(1'b1, 2'b00, 14'd44,   7'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    p2_w   = disp(1'b1, 2'b10, 14'd9999, 7'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    p1a_w  = disp(1'b1, 2'b01, 14'd99,   7'd7, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    p1b_w  = disp(1'b1, 2'b01, 14'd55,   7'd99, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    p0z_w  = disp(1'b0, 2'b00, 14'd44,   7'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    // T1: reset, empty mask keeps everything at 0
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    push_n($urandom_range(4, 8), zero_w);
    drain("t1_idle");
    check("t1_page", {30'd0, cur_page}, 32'd0);
    check("t1_state", {30'd0, fsm_state}, 32'd0);

    // T2: two-page rotation with write clamps
    write_page(2'd0, 14'd300, 7'd0, 2'b00, 1'b0, 1'b0, 2'd0);
    write_page(2'd2, 14'd12000, 7'd0, 2'b10, 1'b0, 1'b0, 2'd0);
    page_mask = 4'b0101;
    push_n(1, zero_w);
    push_n(4, p0_w);
    push_n(4, p2_w);
    push_n(3, p0_w);
    drain("t2_rot");
    check("t2_page", {30'd0, cur_page}, 32'd0);

    // T4: alert raised on the dwell-expiry cycle of p0
    alert_req = 1'b1;
    alert_cnt1 = 14'd42;
    push_n(1, disp(1'b1, 2'b00, 14'd44, 7'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1));
    drain("t4_grant");
    check("t4_page_hold", {30'd0, cur_page}, 32'd0);
    check("t4_state", {30'd0, fsm_state}, 32'd2);
    alert_req = 1'b0;
    push_n(5, disp(1'b1, 2'b10, 14'd42, 7'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1));
    push_n(1, disp(1'b1, 2'b10, 14'd42, 7'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0));
    push_n(4, p0_w);
    push_n(4, p2_w);
    drain("t4_alert");

    // T5: request held through the alert is re-granted right after busy drops
    alert_req = 1'b1;
    alert_cnt1 = 14'd12345;
    push_n(1, disp(1'b1, 2'b00, 14'd44, 7'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1));
    push_n(5, disp(1'b1, 2'b10, 14'd9999, 7'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1));
    push_n(1, disp(1'b1, 2'b10, 14'd9999, 7'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0));
    drain("t5_first");
    av = 14'($urandom_range(0, 9999));
    alert_cnt1 = av;
    push_n(1, disp(1'b1, 2'b00, 14'd44, 7'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1));
    drain("t5_regrant");
    alert_req = 1'b0;
    push_n(1, disp(1'b1, 2'b10, av, 7'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1));
    drain("t5_second");

    // T6b: reset in the middle of an alert
    rst = 1'b1;
    page_mask = 4'b0000;
    push_n(1, zero_w);
    drain("t6_rst");
    rst = 1'b0;
    push_n(2, zero_w);
    drain("t6_after_rst");
    check("t6_rst_page", {30'd0, cur_page}, 32'd0);
    check("t6_rst_state", {30'd0, fsm_state}, 32'd0);

    // page storage was cleared by reset
    page_mask = 4'b0001;
    push_n(1, zero_w);
    push_n(1, disp(1'b1, 2'b00, 14'd0, 7'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0));
    drain("pg_reset");
    page_mask = 4'b0000;
    repeat (2) tick();

    // T3: mode 01 clamp, single enabled page
    write_page(2'd1, 14'd150, 7'd7, 2'b01, 1'b1, 1'b1, 2'd2);
    page_mask = 4'b0010;
    push_n(1, zero_w);
    push_n(9, p1a_w);
    drain("t3_single");
    check("t3_page", {30'd0, cur_page}, 32'd1);

    // write to the shown page lands one cycle after the write edge
    set_wr(2'd1, 14'd55, 7'd120, 2'b01, 1'b1, 1'b1, 2'd2);
    push_n(1, p1a_w);
    drain("wr_edge");
    wr_en = 1'b0;
    push_n(1, p1b_w);
    drain("wr_through");

    // T6a: mask bits dropping force an immediate advance
    write_page(2'd0, 14'd300, 7'd0, 2'b00, 1'b0, 1'b0, 2'd0);
    write_page(2'd2, 14'd12000, 7'd0, 2'b10, 1'b0, 1'b0, 2'd0);
    page_mask = 4'b0101;
    push_n(1, p1b_w);
    drain("t6_drop1");
    check("t6_page2", {30'd0, cur_page}, 32'd2);
    page_mask = 4'b0001;
    push_n(1, p2_w);
    drain("t6_drop2");
    check("t6_page0", {30'd0, cur_page}, 32'd0);
    push_n(1, p0_w);
    drain("t6_p0");

    // empty mask returns to IDLE with outputs held
    page_mask = 4'b0000;
    push_n(1, p0_w);
    push_n(2, p0z_w);
    drain("idle_hold");
    check("idle_state", {30'd0, fsm_state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
